memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Memory stage of the Y86-64 pipeline; consumes the M pipeline register driven by the execute stage.
- Performs data-memory reads and writes over a variable-latency req/ack port.
- Produces the forwarding signals m_valM and m_stat, a stall request m_stall for the hazard unit, and the W pipeline register for write-back.

Parameters:
- MEM_BYTES, 8192, data memory size in bytes; legal 8-byte access needs addr <= MEM_BYTES-8
- TIMEOUT, 16, cycles to wait for dmem_ack before declaring an address error

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- M_stat  in  4  status from execute
- M_icode  in  4  instruction code
- M_cnd  in  1  condition result
- M_valE  in  64  ALU result / effective address
- M_valA  in  64  store data / pop-ret address
- M_dstE  in  4  destination E
- M_dstM  in  4  destination M
- W_stall  in  1  hold W register
- W_bubble  in  1  insert nop into W
- dmem_req  out  1  memory request, held until ack or timeout
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  64  byte address
- dmem_wdata  out  64  write data
- dmem_ack  in  1  request completes this cycle
- dmem_rdata  in  64  read data, valid with dmem_ack
- m_valM  out  64  read data, for forwarding
- m_stat  out  4  effective status, for forwarding
- m_stall  out  1  stage cannot complete this cycle
- W_stat  out  4  registered status
- W_icode  out  4  registered icode
- W_valE  out  64  registered valE
- W_valM  out  64  registered valM
- W_dstE  out  4  registered dstE
- W_dstM  out  4  registered dstM

Behaviour:
- Status codes: AOK=1, HLT=2, ADR=3, INS=4. Register none = 4'hF. NOP icode = 1.
- Address and direction select:
  - Writes: rmmovq (4), pushq (A) and call (8) write M_valA at address M_valE.
  - Reads: mrmovq (5) reads address M_valE; popq (B) and ret (9) read address M_valA.
  - Any other icode performs no access.
- Address error: addr > MEM_BYTES-8 (unsigned). When set, no request is issued, m_stat=ADR, m_valM=0, m_stall=0.
- m_stat:
  - M_stat when M_stat != AOK.
  - Otherwise ADR on address error or timeout.
  - Otherwise M_stat.
- A memory op is issued only if M_stat==AOK.
- FSM has states IDLE and WAIT, plus a counter cnt[$clog2(TIMEOUT):0].
  - IDLE with a valid mem op: dmem_req=1 combinationally, with addr/we/wdata from M.
    - If dmem_ack is high the same cycle: complete, m_stall=0, stay IDLE.
    - Else: m_stall=1, go to WAIT, cnt=1.
  - WAIT: dmem_req held with the same addr/we/wdata; the hazard unit keeps M stable.
    - ack: complete, m_stall=0, go to IDLE.
    - No ack and cnt==TIMEOUT-1: complete with ADR, dmem_req=0 that cycle, go to IDLE.
    - Otherwise cnt+1, m_stall=1.
- m_valM = dmem_rdata on a completing read, else 0.
- W register update (posedge):
  - W_stall: hold.
  - Else W_bubble or m_stall: load a bubble (stat AOK, icode NOP, vals 0, dst F).
  - Else load {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM}.
- M_cnd is consumed upstream only and is ignored here.
- W_stall while completing: the access still completes and the FSM returns to IDLE. The hazard unit must not stall W and complete in the same cycle; the bench asserts this never happens.
- Reset (async, any time including mid-WAIT):
  - State IDLE, cnt 0.
  - W_stat AOK, W_icode NOP, W_valE/W_valM 0, W_dstE/W_dstM F.
  - dmem_req drops immediately.
  - An aborted write may or may not have been performed by memory.

Decomposition:
- Package y86_pkg:
  - icode constants (NOP, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ, ...).
  - stat constants (AOK/HLT/ADR/INS).
  - REG_NONE.
- One natural sub-module, mem_access_ctrl: the FSM, timeout counter, and req/ack handshake. It outputs done, timeout and stall.

Test Plan:
- mrmovq (icode 5), M_valE=0x100, ack same cycle, rdata=0xDEADBEEF → m_stall 0; next posedge W_valM=0xDEADBEEF, W_stat=1.
- pushq (A), valE=0x1F8, valA=0x55, ack after 3 cycles → dmem_we=1, addr 0x1F8, wdata 0x55 stable; m_stall=1 for 3 cycles; W gets bubbles, then the pushq.
- rmmovq with M_valE=8190 (MEM_BYTES=8192) → dmem_req never asserts; m_stat=3; W_stat=3 next edge.
- popq, ack withheld → m_stall for 15 cycles; cycle 16 completes with m_stat=ADR and dmem_req low.
- M_stat=HLT (2) with an mrmovq icode → no request; W_stat=2.
- rst_n low during WAIT → dmem_req low immediately; W_icode=1, W_dstE=F; next mrmovq proceeds normally.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 icode/status encodings and memory-stage types.
//  Revision    : 1.0  initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Req/ack handshake FSM with timeout for the data-memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import y86_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic done,
    output logic timeout,
    output logic stall
);

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req = 1'b1;
                    if (ack) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (ack) begin
                    req     = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: request withdrawn, caller reports ADR.
                    done    = 1'b1;
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : Y86-64 memory stage: data access, forwarding, W register.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        m_stall,
    output logic [3:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    logic        is_wr, is_rd, adr_err, mem_op, start;
    logic        acc_done, acc_timeout;
    logic [63:0] addr;
    logic        unused_cnd;

    assign unused_cnd = M_cnd;

    always_comb begin
        is_wr   = is_mem_write(M_icode);
        is_rd   = is_mem_read(M_icode);
        addr    = ((M_icode == I_POPQ) || (M_icode == I_RET)) ? M_valA : M_valE;
        adr_err = (is_wr || is_rd) && (addr > ADDR_MAX);
        mem_op  = (is_wr || is_rd) && (M_stat == STAT_AOK) && !adr_err;
        // Gating with rst_n makes the request vanish the instant reset asserts.
        start   = mem_op && rst_n;
    end

    mem_access_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ack     (dmem_ack),
        .req     (dmem_req),
        .done    (acc_done),
        .timeout (acc_timeout),
        .stall   (m_stall)
    );

    assign dmem_we    = is_wr;
    assign dmem_addr  = addr;
    assign dmem_wdata = M_valA;

    always_comb begin
        m_valM = (acc_done && !acc_timeout && is_rd) ? dmem_rdata : 64'd0;
        if (M_stat != STAT_AOK)
            m_stat = M_stat;
        else if (adr_err || acc_timeout)
            m_stat = STAT_ADR;
        else
            m_stat = M_stat;
    end

    logic [3:0]  W_stat_q,  W_stat_d;
    logic [3:0]  W_icode_q, W_icode_d;
    logic [63:0] W_valE_q,  W_valE_d;
    logic [63:0] W_valM_q,  W_valM_d;
    logic [3:0]  W_dstE_q,  W_dstE_d;
    logic [3:0]  W_dstM_q,  W_dstM_d;

    always_comb begin
        W_stat_d  = W_stat_q;
        W_icode_d = W_icode_q;
        W_valE_d  = W_valE_q;
        W_valM_d  = W_valM_q;
        W_dstE_d  = W_dstE_q;
        W_dstM_d  = W_dstM_q;
        if (!W_stall) begin
            if (W_bubble || m_stall) begin
                W_stat_d  = STAT_AOK;
                W_icode_d = I_NOP;
                W_valE_d  = 64'd0;
                W_valM_d  = 64'd0;
                W_dstE_d  = REG_NONE;
                W_dstM_d  = REG_NONE;
            end else begin
                W_stat_d  = m_stat;
                W_icode_d = M_icode;
                W_valE_d  = M_valE;
                W_valM_d  = m_valM;
                W_dstE_d  = M_dstE;
                W_dstM_d  = M_dstM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat_q  <= STAT_AOK;
            W_icode_q <= I_NOP;
            W_valE_q  <= 64'd0;
            W_valM_q  <= 64'd0;
            W_dstE_q  <= REG_NONE;
            W_dstM_q  <= REG_NONE;
        end else begin
            W_stat_q  <= W_stat_d;
            W_icode_q <= W_icode_d;
            W_valE_q  <= W_valE_d;
            W_valM_q  <= W_valM_d;
            W_dstE_q  <= W_dstE_d;
            W_dstM_q  <= W_dstM_d;
        end
    end

    assign W_stat  = W_stat_q;
    assign W_icode = W_icode_q;
    assign W_valE  = W_valE_q;
    assign W_valM  = W_valM_q;
    assign W_dstE  = W_dstE_q;
    assign W_dstM  = W_dstM_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Directed scoreboard bench for the Y86-64 memory stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_stage;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic        M_cnd;
    logic [63:0] M_valE, M_valA;
    logic        W_stall, W_bubble;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic        m_stall;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;

    memory_stage #(
        .MEM_BYTES (8192),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_cnd      (M_cnd),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .W_stall    (W_stall),
        .W_bubble   (W_bubble),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .m_valM     (m_valM),
        .m_stat     (m_stat),
        .m_stall    (m_stall),
        .W_stat     (W_stat),
        .W_icode    (W_icode),
        .W_valE     (W_valE),
        .W_valM     (W_valM),
        .W_dstE     (W_dstE),
        .W_dstM     (W_dstM)
    );

    always #5 clk = ~clk;

    typedef logic [143:0] wvec_t;

    wvec_t exp_q[$];
    wvec_t last_w;
    wvec_t w_obs;
    int    vectors     = 0;
    int    miscompares = 0;

    assign w_obs = {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM};

    function automatic wvec_t wpack(input logic [3:0] st, input logic [3:0] ic,
                                    input logic [63:0] ve, input logic [63:0] vm,
                                    input logic [3:0] de, input logic [3:0] dm);
        return {st, ic, ve, vm, de, dm};
    endfunction

    function automatic wvec_t bubble();
        return wpack(STAT_AOK, I_NOP, 64'd0, 64'd0, REG_NONE, REG_NONE);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input wvec_t obs, input wvec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input wvec_t v);
        exp_q.push_back(v);
        last_w = v;
    endtask

    // Advance one edge and compare W against the oldest scoreboard entry.
    task automatic tick();
        wvec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0h expected=entry", w_obs);
        end else begin
            e = exp_q.pop_front();
            checkw("W_reg", w_obs, e);
        end
    endtask

    task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                           input logic [63:0] ve, input logic [63:0] va,
                           input logic [3:0] de, input logic [3:0] dm);
        M_stat  = st;
        M_icode = ic;
        M_valE  = ve;
        M_valA  = va;
        M_dstE  = de;
        M_dstM  = dm;
    endtask

    // The hazard unit must never stall W on a completing access.
    always @(negedge clk) begin
        if (rst_n && W_stall && dmem_req && dmem_ack) begin
            miscompares++;
            $error("FAIL wstall_on_complete observed=1 expected=0");
        end
    end

    initial begin
        rst_n      = 1'b0;
        M_cnd      = 1'b0;
        W_stall    = 1'b0;
        W_bubble   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
        drive_m(STAT_AOK, I_NOP, 64'd0, 64'd0, REG_NONE, REG_NONE);
        #7;
        checkw("reset_W", w_obs, bubble());
        check("reset_req", {63'd0, dmem_req}, 64'd0);
        last_w = bubble();
        rst_n  = 1'b1;
        push_w(bubble());
        tick();

        // mrmovq, ack in the same cycle
        drive_m(STAT_AOK, I_MRMOVQ, 64'h100, 64'd0, REG_NONE, 4'h3);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        #3;
        check("mr_req",   {63'd0, dmem_req}, 64'd1);
        check("mr_we",    {63'd0, dmem_we}, 64'd0);
        check("mr_addr",  dmem_addr, 64'h100);
        check("mr_stall", {63'd0, m_stall}, 64'd0);
        check("mr_valM",  m_valM, 64'hDEADBEEF);
        check("mr_stat",  {60'd0, m_stat}, 64'(STAT_AOK));
        push_w(wpack(STAT_AOK, I_MRMOVQ, 64'h100, 64'hDEADBEEF, REG_NONE, 4'h3));
        tick();

        // W_stall holds the previous contents
        dmem_ack = 1'b0;
        W_stall  = 1'b1;
        drive_m(STAT_AOK, I_IRMOVQ, 64'h77, 64'd0, 4'h5, REG_NONE);
        push_w(last_w);
        tick();
        W_stall  = 1'b0;

        // W_bubble overrides a non-memory instruction, then it loads
        W_bubble = 1'b1;
        #3;
        check("ir_req", {63'd0, dmem_req}, 64'd0);
        push_w(bubble());
        tick();
        W_bubble = 1'b0;
        push_w(wpack(STAT_AOK, I_IRMOVQ, 64'h77, 64'd0, 4'h5, REG_NONE));
        tick();

        // pushq, ack arrives after three stalled cycles
        drive_m(STAT_AOK, I_PUSHQ, 64'h1F8, 64'h55, 4'h4, REG_NONE);
        for (int i = 0; i < 3; i++) begin
            #3;
            check("push_req",   {63'd0, dmem_req}, 64'd1);
            check("push_we",    {63'd0, dmem_we}, 64'd1);
            check("push_addr",  dmem_addr, 64'h1F8);
            check("push_wdata", dmem_wdata, 64'h55);
            check("push_stall", {63'd0, m_stall}, 64'd1);
            push_w(bubble());
            tick();
        end
        dmem_ack = 1'b1;
        #3;
        check("push_ack_req",   {63'd0, dmem_req}, 64'd1);
        check("push_ack_stall", {63'd0, m_stall}, 64'd0);
        check("push_ack_valM",  m_valM, 64'd0);
        push_w(wpack(STAT_AOK, I_PUSHQ, 64'h1F8, 64'd0, 4'h4, REG_NONE));
        tick();
        dmem_ack = 1'b0;

        // rmmovq at 8190 is out of range
        drive_m(STAT_AOK, I_RMMOVQ, 64'd8190, 64'h99, REG_NONE, REG_NONE);
        #3;
        check("adr_req",   {63'd0, dmem_req}, 64'd0);
        check("adr_stat",  {60'd0, m_stat}, 64'(STAT_ADR));
        check("adr_stall", {63'd0, m_stall}, 64'd0);
        push_w(wpack(STAT_ADR, I_RMMOVQ, 64'd8190, 64'd0, REG_NONE, REG_NONE));
        tick();

        // rmmovq at 8184 is the last legal address
        drive_m(STAT_AOK, I_RMMOVQ, 64'd8184, 64'h99, REG_NONE, REG_NONE);
        dmem_ack = 1'b1;
        #3;
        check("edge_req",  {63'd0, dmem_req}, 64'd1);
        check("edge_stat", {60'd0, m_stat}, 64'(STAT_AOK));
        push_w(wpack(STAT_AOK, I_RMMOVQ, 64'd8184, 64'd0, REG_NONE, REG_NONE));
        tick();
        dmem_ack = 1'b0;

        // popq with ack withheld times out on the 16th cycle
        drive_m(STAT_AOK, I_POPQ, 64'h208, 64'h200, 4'h4, 4'h2);
        for (int i = 0; i < 15; i++) begin
            #3;
            check("pop_req",   {63'd0, dmem_req}, 64'd1);
            check("pop_addr",  dmem_addr, 64'h200);
            check("pop_stall", {63'd0, m_stall}, 64'd1);
            push_w(bubble());
            tick();
        end
        #3;
        check("to_req",   {63'd0, dmem_req}, 64'd0);
        check("to_stall", {63'd0, m_stall}, 64'd0);
        check("to_stat",  {60'd0, m_stat}, 64'(STAT_ADR));
        check("to_valM",  m_valM, 64'd0);
        push_w(wpack(STAT_ADR, I_POPQ, 64'h208, 64'd0, 4'h4, 4'h2));
        tick();

        // incoming HLT status suppresses the access
        drive_m(STAT_HLT, I_MRMOVQ, 64'h100, 64'd0, REG_NONE, 4'h3);
        #3;
        check("hlt_req",  {63'd0, dmem_req}, 64'd0);
        check("hlt_stat", {60'd0, m_stat}, 64'(STAT_HLT));
        push_w(wpack(STAT_HLT, I_MRMOVQ, 64'h100, 64'd0, REG_NONE, 4'h3));
        tick();

        // reset asserted while waiting
        drive_m(STAT_AOK, I_MRMOVQ, 64'h300, 64'd0, REG_NONE, 4'h6);
        #3;
        check("rw_stall", {63'd0, m_stall}, 64'd1);
        push_w(bubble());
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_req",   {63'd0, dmem_req}, 64'd0);
        check("rw_icode", {60'd0, W_icode}, 64'(I_NOP));
        check("rw_dstE",  {60'd0, W_dstE}, 64'(REG_NONE));
        push_w(bubble());
        tick();
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1234;
        #3;
        check("post_req",   {63'd0, dmem_req}, 64'd1);
        check("post_stall", {63'd0, m_stall}, 64'd0);
        check("post_valM",  m_valM, 64'h1234);
        push_w(wpack(STAT_AOK, I_MRMOVQ, 64'h300, 64'h1234, REG_NONE, 4'h6));
        tick();
        dmem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
